button_debouncer: RTL and testbench

//  Conditions a raw push-button input into a clean level and single-cycle strobes.

---
 rtl/seg7_pkg.sv | 18 +
 rtl/button_debouncer_if.sv | 23 ++
 rtl/button_debouncer_sync.sv | 21 ++
 rtl/button_debouncer.sv | 150 +++++++++++++++
 tb/tb_button_debouncer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment front end: debouncer FSM encodings and
// default timing for the 3.125 MHz system clock.
package seg7_pkg;

    typedef logic [1:0] btn_state_t;

    localparam btn_state_t ST_IDLE         = 2'd0;
    localparam btn_state_t ST_PRESS_WAIT   = 2'd1;
    localparam btn_state_t ST_HELD         = 2'd2;
    localparam btn_state_t ST_RELEASE_WAIT = 2'd3;

    // 20 ms debounce, 500 ms first repeat, 200 ms repeat period at 3.125 MHz.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 62500;
    localparam int unsigned DEF_CNT_W           = 22;
    localparam int unsigned DEF_REPEAT_DELAY    = 1562500;
    localparam int unsigned DEF_REPEAT_PERIOD   = 625000;

endpackage

// File: rtl/button_debouncer_if.sv
// Button pin and conditioned outputs between the debouncer and its environment.
interface button_debouncer_if;

    logic btn_raw;
    logic btn_level;
    logic btn_pulse;
    logic btn_release;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_pulse,
        input  btn_release
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_pulse,
        output btn_release
    );

endinterface

// File: rtl/button_debouncer_sync.sv
// Two-flop synchronizer for a single asynchronous pin, async active-low reset to 0.
module btn_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronizer, debounce FSM, registered level and strobes.
// Define BUTTON_DEBOUNCER_AUTOREPEAT_EN to enable auto-repeat pulses while held.
module button_debouncer
    import seg7_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
    input logic               clk,
    input logic               reset,
    button_debouncer_if.slave btn
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             btn_s;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic             release_q, release_d;
    logic             repeat_hit;

    btn_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn.btn_raw),
        .q     (btn_s)
    );

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             rfirst_q, rfirst_d;

    // Held outside HELD so every entry, including a bounce back from RELEASE_WAIT, starts fresh.
    always_comb begin
        rcnt_d     = rcnt_q;
        rfirst_d   = rfirst_q;
        repeat_hit = 1'b0;
        if (state_q != ST_HELD) begin
            rcnt_d   = '0;
            rfirst_d = 1'b1;
        end else if (btn_s) begin
            if (rcnt_q == (rfirst_q ? RD_LAST : RP_LAST)) begin
                repeat_hit = 1'b1;
                rcnt_d     = '0;
                rfirst_d   = 1'b0;
            end else begin
                rcnt_d = rcnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rcnt_q   <= '0;
            rfirst_q <= 1'b1;
        end else begin
            rcnt_q   <= rcnt_d;
            rfirst_q <= rfirst_d;
        end
    end
`else
    assign repeat_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        pulse_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (btn_s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!btn_s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end else begin
                    pulse_d = repeat_hit;
                end
            end
            ST_RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            release_q <= release_d;
        end
    end

    assign btn.btn_level   = level_q;
    assign btn.btn_pulse   = pulse_q;
    assign btn.btn_release = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random bursts against a run-length model.
module tb_button_debouncer;

    localparam int DB = 8;
    localparam int RD = 20;
    localparam int RP = 5;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;

    button_debouncer_if bif ();

    button_debouncer #(
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (8)
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (bif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: the accepted level flips once the synchronized pin has disagreed with it
    // for DB+1 consecutive samples; repeats are timed from the last return to a steady press.
    logic m_f1, m_s, m_lvl, e_pulse, e_rel;
    int   m_run, m_elapsed;

    int win_pulses, win_rel, win_level_hi, first_pulse, first_rel, step_idx;

    task automatic model_reset();
        m_f1 = 1'b0; m_s = 1'b0; m_lvl = 1'b0;
        e_pulse = 1'b0; e_rel = 1'b0;
        m_run = 0; m_elapsed = 0;
    endtask

    task automatic model_edge(input logic raw);
        logic samp;
        samp = m_s;
        m_s  = m_f1;
        m_f1 = raw;
        e_pulse = 1'b0;
        e_rel   = 1'b0;
        if (samp != m_lvl) begin
            m_run++;
            if (m_run == DB + 1) begin
                m_lvl = samp;
                m_run = 0;
                if (samp) begin
                    e_pulse   = 1'b1;
                    m_elapsed = 0;
                end else begin
                    e_rel = 1'b1;
                end
            end
        end else begin
            if (m_lvl) begin
                if (m_run > 0) begin
                    m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (AUTO && m_elapsed >= RD && ((m_elapsed - RD) % RP) == 0) e_pulse = 1'b1;
                end
            end
            m_run = 0;
        end
    endtask

    task automatic win_start();
        win_pulses = 0; win_rel = 0; win_level_hi = 0;
        first_pulse = -1; first_rel = -1; step_idx = 0;
    endtask

    task automatic step(input logic raw);
        bif.btn_raw = raw;
        @(posedge clk);
        if (!reset) model_reset();
        else model_edge(raw);
        #1;
        check_eq("level", bif.btn_level, m_lvl);
        check_eq("pulse", bif.btn_pulse, e_pulse);
        check_eq("release", bif.btn_release, e_rel);
        if (bif.btn_pulse === 1'b1) begin
            win_pulses++;
            if (first_pulse < 0) first_pulse = step_idx;
        end
        if (bif.btn_release === 1'b1) begin
            win_rel++;
            if (first_rel < 0) first_rel = step_idx;
        end
        if (bif.btn_level === 1'b1) win_level_hi++;
        step_idx++;
    endtask

    task automatic async_reset_check(input string tag);
        reset = 1'b0;
        model_reset();
        #1;
        check_eq({tag, "_level"}, bif.btn_level, 0);
        check_eq({tag, "_pulse"}, bif.btn_pulse, 0);
        check_eq({tag, "_release"}, bif.btn_release, 0);
    endtask

    initial begin
        bif.btn_raw = 1'b0;
        model_reset();
        win_start();
        repeat (3) step(1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) step(1'b0);

        // Clean press
        win_start();
        repeat (26) step(1'b1);
        check_eq("t1_pulses", win_pulses, 1);
        check_eq("t1_latency", first_pulse, 10);
        check_eq("t1_level", bif.btn_level, 1);

        // Release with two 4-cycle glitches
        win_start();
        repeat (3) step(1'b0);
        repeat (4) step(1'b1);
        repeat (3) step(1'b0);
        repeat (4) step(1'b1);
        repeat (20) step(1'b0);
        check_eq("t3_releases", win_rel, 1);
        check_eq("t3_rel_latency", first_rel, 24);
        check_eq("t3_pulses", win_pulses, 0);
        check_eq("t3_level", bif.btn_level, 0);

        // Bounce every 3 cycles, then settle high
        win_start();
        for (int i = 0; i < 40; i++) step(((i / 3) % 2) == 0);
        repeat (30) step(1'b1);
        check_eq("t2_pulses", win_pulses, 1);
        check_eq("t2_latency", first_pulse, 50);
        repeat (20) step(1'b0);

        // Reset while in PRESS_WAIT, then release reset with the button still down
        win_start();
        repeat (8) step(1'b1);
        async_reset_check("t4_rst");
        repeat (2) step(1'b1);
        @(negedge clk);
        reset = 1'b1;
        win_start();
        repeat (20) step(1'b1);
        check_eq("t4_pulses", win_pulses, 1);
        check_eq("t4_latency", first_pulse, 10);
        repeat (20) step(1'b0);

        // 7-cycle glitch must be ignored
        win_start();
        repeat (7) step(1'b1);
        repeat (20) step(1'b0);
        check_eq("t5_pulses", win_pulses, 0);
        check_eq("t5_level_hi", win_level_hi, 0);
        check_eq("t5_releases", win_rel, 0);

        // Long hold: auto-repeat count depends on the build
        win_start();
        repeat (70) step(1'b1);
        check_eq("t6_pulses", win_pulses, AUTO ? 9 : 1);
        check_eq("t6_level", bif.btn_level, 1);
        async_reset_check("t6_rst");
        repeat (2) step(1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Random bursts, checked cycle by cycle against the model
        win_start();
        for (int b = 0; b < 150; b++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 40))
                                              : int'($urandom_range(1, 12));
            repeat (len) step(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
